// File: rtl/gpio_bus_arbiter.sv
// Two-master arbiter onto the GPIO data/direction registers; req->ack is 2 cycles, one grant every 3 cycles.
// Backpressure: masters hold req until their ack; requests seen outside IDLE simply wait.
module gpio_bus_arbiter #(
  parameter int unsigned FIXED_PRIO = 0,
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_we,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_we,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rdata,
  output logic [31:0] address,
  output logic [31:0] write_data,
  output logic        write_enable,
  input  logic [31:0] read_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        we_q, gnt_q, last_grant_q;
  logic        any_req, win, valid;

  assign any_req = m0_req | m1_req;
  assign valid   = (addr_q == BASE_ADDR) || (addr_q == (BASE_ADDR + 32'd4));

  always_comb begin
    win = 1'b0;
    if (FIXED_PRIO != 0) begin
      win = ~m0_req;
    end else if (m0_req && m1_req) begin
      // last_grant resets to 1 so m0 takes the first tie
      win = ~last_grant_q;
    end else begin
      win = ~m0_req;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = any_req ? ACCESS : IDLE;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      we_q         <= 1'b0;
      gnt_q        <= 1'b0;
      last_grant_q <= 1'b1;
      rdata_q      <= 32'h0;
    end else begin
      if (state_q == IDLE && any_req) begin
        addr_q       <= win ? m1_addr  : m0_addr;
        wdata_q      <= win ? m1_wdata : m0_wdata;
        we_q         <= win ? m1_we    : m0_we;
        gnt_q        <= win;
        last_grant_q <= win;
      end
      if (state_q == ACCESS) begin
        rdata_q <= valid ? read_data : 32'h0;
      end
    end
  end

  always_comb begin
    address      = 32'h0;
    write_data   = 32'h0;
    write_enable = 1'b0;
    m0_ack       = 1'b0;
    m0_err       = 1'b0;
    m1_ack       = 1'b0;
    m1_err       = 1'b0;
    if (state_q == ACCESS) begin
      address      = addr_q;
      write_data   = wdata_q;
      write_enable = we_q & valid;
    end
    if (state_q == RESP) begin
      m0_ack = ~gnt_q;
      m0_err = ~gnt_q & ~valid;
      m1_ack = gnt_q;
      m1_err = gnt_q & ~valid;
    end
  end

  assign m0_rdata = rdata_q;
  assign m1_rdata = rdata_q;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Bench for gpio_bus_arbiter: scoreboard of expected acks plus directed cycle checks.
module tb_gpio_bus_arbiter;
  localparam logic [31:0] BASE = 32'hFFFF0010;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
  logic        m0_ack, m0_err, m1_ack, m1_err, write_enable;
  logic [31:0] m0_rdata, m1_rdata, address, write_data, read_data;
  logic        fp_m0_ack, fp_m0_err, fp_m1_ack, fp_m1_err, fp_we;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_address, fp_wdata;

  gpio_bus_arbiter #(.FIXED_PRIO(0), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .address(address), .write_data(write_data), .write_enable(write_enable),
    .read_data(read_data)
  );

  gpio_bus_arbiter #(.FIXED_PRIO(1), .BASE_ADDR(BASE)) dut_fp (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_ack(fp_m0_ack), .m0_err(fp_m0_err), .m0_rdata(fp_m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_ack(fp_m1_ack), .m1_err(fp_m1_err), .m1_rdata(fp_m1_rdata),
    .address(fp_address), .write_data(fp_wdata), .write_enable(fp_we),
    .read_data(read_data)
  );

  // GPIO register block behind the main arbiter; unmapped reads return junk
  logic [31:0] gpio_data = 32'h000000A5;
  logic [31:0] gpio_dir  = 32'h0;
  always_comb read_data = (address == BASE) ? gpio_data :
                          (address == BASE + 32'd4) ? gpio_dir : 32'hDEADBEEF;
  always @(posedge clk) begin
    if (write_enable) begin
      if (address == BASE) gpio_data <= write_data;
      else if (address == BASE + 32'd4) gpio_dir <= write_data;
    end
  end

  typedef struct packed {
    logic        m;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] mdl_data = 32'h000000A5;
  logic [31:0] mdl_dir  = 32'h0;
  int n_checks = 0, n_errors = 0;
  int ack_cnt = 0, we_cycles = 0, fp_acks = 0;
  bit fp_phase = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic expect_txn(input logic m, input logic [31:0] a, input logic [31:0] wd, input logic we);
    logic v;
    exp_t e;
    v = (a == BASE) || (a == BASE + 32'd4);
    e.m     = m;
    e.err   = ~v;
    e.rdata = !v ? 32'h0 : (a == BASE) ? mdl_data : mdl_dir;
    sb.push_back(e);
    if (v && we) begin
      if (a == BASE) mdl_data = wd;
      else mdl_dir = wd;
    end
  endtask

  task automatic drive(input logic m, input logic req, input logic [31:0] a, input logic [31:0] wd, input logic we);
    if (m == 1'b0) begin
      m0_req = req; m0_addr = a; m0_wdata = wd; m0_we = we;
    end else begin
      m1_req = req; m1_addr = a; m1_wdata = wd; m1_we = we;
    end
  endtask

  task automatic do_txn(input logic m, input logic [31:0] a, input logic [31:0] wd, input logic we, input bit drop_early);
    logic v;
    v = (a == BASE) || (a == BASE + 32'd4);
    expect_txn(m, a, wd, we);
    @(negedge clk);
    drive(m, 1'b1, a, wd, we);
    @(posedge clk); @(negedge clk);
    chk("acc_addr", address, a);
    chk("acc_wdata", write_data, wd);
    chk("acc_we", write_enable, we & v);
    if (drop_early) drive(m, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("lat_ack", m ? m1_ack : m0_ack, 1);
    chk("resp_we", write_enable, 0);
    drive(m, 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); @(negedge clk);
    chk("idle_ack", m0_ack | m1_ack, 0);
    chk("idle_addr", address, 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      we_cycles = 0;
    end else begin
      if (write_enable) we_cycles++;
      if (m0_ack || m1_ack) begin
        chk("dual_ack", m0_ack & m1_ack, 0);
        chk("we_per_grant", we_cycles > 1, 0);
        chk("other_err", m1_ack ? m0_err : m1_err, 0);
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("ack_master", m1_ack, mon_e.m);
          chk("ack_err", m1_ack ? m1_err : m0_err, mon_e.err);
          chk("ack_rdata", m1_ack ? m1_rdata : m0_rdata, mon_e.rdata);
        end
        ack_cnt++;
        we_cycles = 0;
      end
      if (fp_phase && (fp_m0_ack || fp_m1_ack)) begin
        chk("fp_winner_m0", fp_m0_ack, 1);
        fp_acks++;
      end
    end
  end

  initial begin
    int start;
    int cyc;
    repeat (3) @(negedge clk);
    chk("rst_address", address, 0);
    chk("rst_wdata", write_data, 0);
    chk("rst_we", write_enable, 0);
    chk("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 0);
    chk("rst_rdata", m0_rdata, 0);
    rst = 1'b1;

    do_txn(1'b0, BASE + 32'd4, 32'h000000FF, 1'b1, 1'b0);
    do_txn(1'b1, BASE, 32'h0, 1'b0, 1'b0);

    // both masters held: round-robin alternates, fixed-priority copy serves only m0
    expect_txn(1'b0, BASE, 32'h0, 1'b0);
    expect_txn(1'b1, BASE + 32'd4, 32'h0, 1'b0);
    expect_txn(1'b0, BASE, 32'h0, 1'b0);
    expect_txn(1'b1, BASE + 32'd4, 32'h0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, BASE, 32'h0, 1'b0);
    drive(1'b1, 1'b1, BASE + 32'd4, 32'h0, 1'b0);
    fp_phase = 1;
    start = ack_cnt;
    cyc = 0;
    while (ack_cnt < start + 4 && cyc < 60) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("arb_grants", ack_cnt - start, 4);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (3) @(negedge clk);
    fp_phase = 0;
    chk("fp_acks_seen", fp_acks != 0, 1);

    do_txn(1'b0, 32'hFFFF0020, 32'h00001234, 1'b1, 1'b0);
    do_txn(1'b1, 32'hFFFF0018, 32'h0, 1'b0, 1'b1);
    do_txn(1'b0, BASE, 32'h0, 1'b0, 1'b1);

    // reset in the middle of an m1 write, request kept pending across it
    @(negedge clk);
    drive(1'b1, 1'b1, BASE, 32'h00000055, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("pre_rst_we", write_enable, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_we", write_enable, 0);
    chk("arst_addr", address, 0);
    chk("arst_wdata", write_data, 0);
    chk("arst_rdata", m1_rdata, 0);
    @(posedge clk); @(negedge clk);
    chk("arst_no_ack", m1_ack, 0);
    #1 rst = 1'b1;
    expect_txn(1'b1, BASE, 32'h00000055, 1'b1);
    @(posedge clk); @(negedge clk);
    chk("regrant_addr", address, BASE);
    chk("regrant_we", write_enable, 1);
    @(posedge clk); @(negedge clk);
    chk("regrant_ack", m1_ack, 1);
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);

    do_txn(1'b0, BASE, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/gpio_bus_arbiter.md
GPIO_BUS_ARBITER -- requirements
Module: gpio_bus_arbiter

Interface
REQ-001 The block SHALL provide parameter FIXED_PRIO, default 0, meaning 0 = round-robin arbitration and 1 = master 0 always wins.
REQ-002 The block SHALL provide parameter BASE_ADDR, default 32'hFFFF0010, meaning the data register address; BASE_ADDR+4 is the direction register address.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 m0_req, m1_req  input  1 each  master request, held until the matching ack.
REQ-006 m0_addr, m1_addr  input  32 each  master address, stable while req is high.
REQ-007 m0_wdata, m1_wdata  input  32 each  master write data, stable while req is high.
REQ-008 m0_we, m1_we  input  1 each  1 = write, 0 = read; stable while req is high.
REQ-009 m0_ack, m1_ack  output  1 each  one-cycle completion pulse.
REQ-010 m0_err, m1_err  output  1 each  one-cycle pulse, coincident with ack, flagging an unmapped address.
REQ-011 m0_rdata, m1_rdata  output  32 each  read data, valid during the ack cycle.
REQ-012 address  output  32  slave address to the GPIO register block.
REQ-013 write_data  output  32  slave write data.
REQ-014 write_enable  output  1  slave write strobe.
REQ-015 read_data  input  32  slave combinational read data.

Function
REQ-016 The FSM SHALL have states IDLE, ACCESS and RESP, encoded in 2 bits, with no other reachable state.
REQ-017 In IDLE, if any req is high at a rising edge, the block SHALL select a winner, register that winner's addr/wdata/we plus a grant index, and enter ACCESS.
REQ-018 Arbitration, FIXED_PRIO=0: a lone requester wins; if both request, the master not granted last wins; the last_grant register updates on each grant.
REQ-019 Arbitration, FIXED_PRIO=1: m0 wins whenever m0_req is high.
REQ-020 A request is "valid" only if its latched address equals BASE_ADDR or BASE_ADDR+4.
REQ-021 In ACCESS, address and write_data SHALL be driven from the latched registers, and write_enable SHALL be 1 for exactly this one cycle iff latched we=1 and the request is valid.
REQ-022 At the rising edge that ends ACCESS, the block SHALL capture read_data into an internal rdata register (32'h0 if the request is invalid) and enter RESP.
REQ-023 In RESP, the granted master's ack SHALL be 1 and its err SHALL equal the inverse of valid; the other master's ack/err SHALL stay 0; the FSM then returns unconditionally to IDLE.
REQ-024 m0_rdata and m1_rdata SHALL both present the rdata register; it is meaningful only during the ack cycle and is not cleared afterwards.
REQ-025 Latency: req first seen at edge N; ACCESS during cycle N+1; ack during cycle N+2; IDLE during cycle N+3. Minimum spacing between grants is 3 cycles.
REQ-026 A write to an unmapped address SHALL never assert write_enable; a read of an unmapped address SHALL return 32'h0 with err=1.
REQ-027 Outside ACCESS, address, write_data and write_enable SHALL all be 0.
REQ-028 A master that drops req during ACCESS or RESP SHALL have no effect on the transaction, which completes and acks normally.
REQ-029 A master still requesting in the IDLE cycle after its ack is a new request and SHALL be arbitrated normally.
REQ-030 A request arriving in ACCESS or RESP SHALL wait; arbitration happens only in IDLE.

Reset
REQ-031 When rst is low, the block SHALL asynchronously force: state=IDLE; all acks, errs and write_enable = 0; address, write_data and rdata = 32'h0; last_grant = 1, so m0 wins the first tie.
REQ-032 A reset asserted in ACCESS or RESP SHALL abort the transaction with no ack and no further write_enable; a write already strobed is not undone.
REQ-033 After rst deasserts, the first arbitration SHALL occur at the first rising edge on which rst is high and a req is high.

Verification
REQ-034 Reset, then m0 write addr=32'hFFFF0014, wdata=32'h000000FF -> write_enable=1 for one cycle with address 32'hFFFF0014 and write_data 32'h000000FF; m0_ack=1 two cycles after request; m0_err=0.
REQ-035 m1 read addr=32'hFFFF0010 with read_data=32'h000000A5 -> m1_ack pulse with m1_rdata=32'h000000A5; write_enable stays 0.
REQ-036 m0 and m1 request simultaneously, held continuously -> grants in order m0, m1, m0, m1 (FIXED_PRIO=0); with FIXED_PRIO=1 -> every grant goes to m0.
REQ-037 m0 write to 32'hFFFF0020 -> no write_enable; m0_ack=1, m0_err=1, m0_rdata=32'h0.
REQ-038 rst driven low during ACCESS of an m1 write -> m1_ack never pulses; outputs are zero immediately; after release, a pending m1_req is granted at the first edge.
REQ-039 A bench assertion SHALL fail if ack is ever set for both masters in one cycle, or if write_enable is asserted for more than one cycle per grant.
